// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtractor. A single 1-bit difference/borrow
// cell is stepped over the operands LSB first. A borrow register carries the
// borrow between bits. Operands come in over a start/ready handshake and the
// result leaves over a valid/ready handshake. Every output is a flop.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] diff,
  output logic             borr,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  // The counter only reaches WIDTH on the final shift edge, so this width
  // cannot wrap inside a transaction.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One subtractor cell: returns {borrow_next, difference_bit}.
  function automatic logic [1:0] sub_cell(input logic a0, input logic b0, input logic br);
    logic d;
    logic br_next;
    d       = a0 ^ b0 ^ br;
    br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
    return {br_next, d};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borr_q, borr_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [1:0]       cell_s;
  logic [WIDTH-1:0] res_shift_s;

  // State and datapath registers, with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      res_q       <= {WIDTH{1'b0}};
      br_q        <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      diff_q      <= {WIDTH{1'b0}};
      borr_q      <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      br_q        <= br_d;
      cnt_q       <= cnt_d;
      diff_q      <= diff_d;
      borr_q      <= borr_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic. The handshake flags are computed here for the state
  // being entered, so they can be registered along with the state.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    br_d        = br_q;
    cnt_d       = cnt_q;
    diff_d      = diff_q;
    borr_d      = borr_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;

    cell_s      = sub_cell(a_q[0], b_q[0], br_q);
    res_shift_s = {cell_s[0], res_q[WIDTH-1:1]};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // The borrow register takes only bin, so no borrow is left over
          // from a previous transaction.
          a_d        = a;
          b_d        = b;
          br_d       = bin;
          res_d      = {WIDTH{1'b0}};
          cnt_d      = {CW{1'b0}};
          state_d    = ST_SHIFT;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = cell_s[1];
        res_d = res_shift_s;
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_BIT) begin
          state_d     = ST_DONE;
          diff_d      = res_shift_s;
          borr_d      = cell_s[1];
          zero_d      = (res_shift_s == {WIDTH{1'b0}});
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d     = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d     = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign diff      = diff_q;
  assign borr      = borr_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed testbench for serial_sub_ctrl (WIDTH=8). Inputs are driven and
// outputs are sampled 1 ns after each rising edge.
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             in_ready;
  logic             busy;
  logic [WIDTH-1:0] diff;
  logic             borr;
  logic             zero;
  logic             out_valid;
  logic             out_ready;

  int n_vec  = 0;
  int n_miss = 0;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_ready  (in_ready),
    .busy      (busy),
    .diff      (diff),
    .borr      (borr),
    .zero      (zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set for a single edge.
  task automatic do_load(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    a     = av;
    b     = bv;
    bin   = bi;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for out_valid, bounded; lat counts edges after the load edge.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_vec({tag, "_acc_valid"}, 32'(out_valid), 32'd0);
    check_vec({tag, "_acc_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, input logic [7:0] ed, input logic eb, input logic ez);
    int lat;
    do_load(av, bv, bi);
    wait_valid(lat);
    check_vec({tag, "_lat"},  32'(lat),  32'd8);
    check_vec({tag, "_diff"}, 32'(diff), 32'(ed));
    check_vec({tag, "_borr"}, 32'(borr), 32'(eb));
    check_vec({tag, "_zero"}, 32'(zero), 32'(ez));
    accept(tag);
  endtask

  initial begin
    int lat;
    int t0, t1, n_loads, n_res;
    logic prev_ir;

    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check_vec("rst_in_ready",  32'(in_ready),  32'd1);
    check_vec("rst_busy",      32'(busy),      32'd0);
    check_vec("rst_out_valid", 32'(out_valid), 32'd0);
    check_vec("rst_diff",      32'(diff),      32'd0);
    check_vec("rst_borr",      32'(borr),      32'd0);
    check_vec("rst_zero",      32'(zero),      32'd0);
    rst_n = 1'b1;
    tick();

    // Basic operation, with busy, backpressure and accept checks.
    do_load(8'h5A, 8'h23, 1'b0);
    check_vec("b1_busy",     32'(busy),     32'd1);
    check_vec("b1_in_ready", 32'(in_ready), 32'd0);
    wait_valid(lat);
    check_vec("b1_lat",  32'(lat),  32'd8);
    check_vec("b1_diff", 32'(diff), 32'h37);
    check_vec("b1_borr", 32'(borr), 32'd0);
    check_vec("b1_zero", 32'(zero), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_vec("bp_valid", 32'(out_valid), 32'd1);
      check_vec("bp_diff",  32'(diff),      32'h37);
      check_vec("bp_borr",  32'(borr),      32'd0);
      check_vec("bp_zero",  32'(zero),      32'd0);
    end
    accept("b1");
    check_vec("b1_hold_diff", 32'(diff), 32'h37);

    run_op("v2", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
    run_op("v3", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("v4", 8'h7F, 8'h7F, 1'b0, 8'h00, 1'b0, 1'b1);
    run_op("v5", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1);

    // A start pulse while SHIFT is running must be ignored.
    do_load(8'h5A, 8'h23, 1'b0);
    tick(); tick();
    a = 8'hFF; b = 8'h01; bin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    check_vec("ign_lat",  32'(lat + 3), 32'd8);
    check_vec("ign_diff", 32'(diff),    32'h37);
    check_vec("ign_borr", 32'(borr),    32'd0);
    accept("ign");
    for (int i = 0; i < 12; i++) begin
      tick();
      check_vec("ign_no_second", 32'(out_valid), 32'd0);
    end

    // Reset in the middle of SHIFT aborts the transaction.
    do_load(8'hFF, 8'h01, 1'b1);
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check_vec("arst_in_ready", 32'(in_ready),  32'd1);
    check_vec("arst_busy",     32'(busy),      32'd0);
    check_vec("arst_valid",    32'(out_valid), 32'd0);
    check_vec("arst_diff",     32'(diff),      32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_vec("arst_rel_ready", 32'(in_ready), 32'd1);
    run_op("post", 8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Back-to-back issue with start and out_ready held high.
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1; out_ready = 1'b1;
    t0 = 0; t1 = 0; n_loads = 0; n_res = 0; prev_ir = in_ready;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      if (prev_ir && !in_ready) begin
        n_loads++;
        if (n_loads == 1) begin
          t0 = cyc; a = 8'h10; b = 8'h20;
        end else begin
          t1 = cyc; start = 1'b0;
        end
      end
      if (out_valid) begin
        n_res++;
        if (n_res == 1) check_vec("b2b_diff1", 32'(diff), 32'h37);
        else            check_vec("b2b_diff2", 32'(diff), 32'hF0);
      end
      prev_ir = in_ready;
    end
    out_ready = 1'b0;
    check_vec("b2b_loads",    32'(n_loads), 32'd2);
    check_vec("b2b_interval", 32'(t1 - t0), 32'd10);
    check_vec("b2b_results",  32'(n_res),   32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Multi-bit subtract engine that sequences a single 1-bit subtractor cell (difference/borrow datapath) bit-serially, LSB first, with a borrow register between bits.
- Accepts two WIDTH-bit operands and a borrow-in over a start/ready handshake.
- Returns difference, borrow-out and zero flag over a valid/ready handshake.
- Sits between an operand source and a result consumer. It replaces a WIDTH-wide ripple subtractor where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin a subtraction; sampled only when in_ready=1
- a  input  WIDTH  minuend, captured when start&&in_ready
- b  input  WIDTH  subtrahend, captured when start&&in_ready
- bin  input  1  borrow-in, captured when start&&in_ready
- in_ready  output  1  high only in IDLE
- busy  output  1  high in SHIFT
- diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH; valid while out_valid
- borr  output  1  borrow-out: 1 iff a < b + bin (unsigned)
- zero  output  1  1 iff diff == 0; valid while out_valid
- out_valid  output  1  result available; held until accepted
- out_ready  input  1  consumer accepts result when out_valid&&out_ready

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, in_ready=1, busy=0, out_valid=0.
  - diff=0, borr=0, zero=0.
  - Operand shift registers, borrow register and bit counter all cleared.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States:
  - IDLE: in_ready=1. On start=1, at edge N:
    - capture a, b into shift registers and bin into the borrow register;
    - clear the bit counter;
    - go to SHIFT.
    - start=0: stay in IDLE.
  - SHIFT: busy=1, in_ready=0.
    - Each edge processes the current LSBs a0, b0 with borrow register br:
      - d = a0 ^ b0 ^ br
      - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
    - d shifts into the result register from the MSB end. Both operand registers shift right by 1. The counter increments.
    - On the edge that processes bit WIDTH-1 (edge N+WIDTH), go to DONE and set out_valid=1.
    - diff, borr and zero are updated on that same edge.
  - DONE: out_valid=1.
    - out_ready=1: at the next edge, out_valid=0 and state goes to IDLE. diff, borr and zero keep their last values.
    - out_ready=0: hold all outputs stable indefinitely.
- Latency: start sampled at edge N gives out_valid=1 after edge N+WIDTH. Minimum issue interval is WIDTH+2 cycles (load, WIDTH shifts, 1 accept).
- start while busy or in DONE: ignored, with no side effects. It is not queued.
- a, b and bin changing after capture: no effect on the result in flight.
- out_ready while out_valid=0: ignored.
- Borrow register is cleared at every load, then preset to bin. Borrow never carries between transactions.
- diff is a modulo-2^WIDTH wrap. borr equals the final br after bit WIDTH-1.
- Bit counter width is ceil(log2(WIDTH+1)). The counter must not wrap inside a transaction.
- Reset asserted mid-SHIFT or mid-DONE aborts the transaction and discards the result. After release, the block is in IDLE with in_ready=1 on the first edge.

Test Plan:
- WIDTH=8: a=0x5A, b=0x23, bin=0 → out_valid after 8 cycles; diff=0x37, borr=0, zero=0.
- a=0x10, b=0x20, bin=0 → diff=0xF0, borr=1. Then a=0x00, b=0x00, bin=1 → diff=0xFF, borr=1. Then a=0x7F, b=0x7F, bin=0 → diff=0x00, zero=1, borr=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises → diff, borr, zero and out_valid remain stable. Pulse out_ready=1 → out_valid=0 and in_ready=1 the next cycle.
- start pulsed during SHIFT with a=0xFF, b=0x01 → ignored. The original result 0x37 is delivered and no second result appears.
- Drop rst_n after 4 SHIFT cycles → all outputs go to reset values immediately. New start a=0x03, b=0x01 → diff=0x02, borr=0, with no residue from the aborted operation.
- Back-to-back: start held high across the accept edge → the next operation loads on the cycle after the return to IDLE. Issue interval measures exactly 10 cycles.
